// File: rtl/lsu_seg.sv
// Segmented load/store unit: forms seg:offset bus address, runs one req/ack
// transaction with timeout, and writes load data back to the register file.
//
// state | meaning
// IDLE  | waiting for i_start; bus idle
// REQ   | o_bus_req high, waiting for i_bus_ack or timeout
// WB    | one-cycle completion: o_done, load write-back
module lsu_seg #(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_start,
  input  logic              i_is_store,
  input  logic [15:0]       i_base,
  input  logic [15:0]       i_store_data,
  input  logic [3:0]        i_offset,
  input  logic [3:0]        i_dst,
  input  logic [15:0]       i_seg_d,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [15:0]       o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [15:0]       i_bus_rdata,
  output logic              o_we,
  output logic [3:0]        o_w_addr,
  output logic [15:0]       o_w_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WB = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  dst_q, dst_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [15:0] eff;
  logic [16:0] cnt_inc;
  logic        req;
  logic        wb;

  assign eff     = i_base + {{12{i_offset[3]}}, i_offset};
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    wdata_d    = wdata_q;
    dst_d      = dst_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (i_ce) begin
      // The pending error pulse is consumed by the first enabled cycle.
      err_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d    = REQ;
            is_store_d = i_is_store;
            wdata_d    = i_store_data;
            dst_d      = i_dst;
            addr_d     = {i_seg_d, 4'b0000} + {4'b0000, eff};
            cnt_d      = 16'd0;
          end
        end
        REQ: begin
          if (i_bus_ack) begin
            state_d = WB;
            rdata_d = i_bus_rdata;
          end else if (cnt_inc == 17'(TIMEOUT)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc[15:0];
          end
        end
        WB:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      wdata_q    <= 16'd0;
      dst_q      <= 4'd0;
      addr_q     <= 20'd0;
      rdata_q    <= 16'd0;
      cnt_q      <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      wdata_q    <= wdata_d;
      dst_q      <= dst_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Pulses are gated by i_ce so a stalled cycle neither shows nor consumes them.
  assign req         = (state_q == REQ);
  assign wb          = (state_q == WB);
  assign o_bus_req   = req;
  assign o_bus_we    = req & is_store_q;
  assign o_bus_addr  = req ? ADDR_W'(addr_q) : '0;
  assign o_bus_wdata = (req & is_store_q) ? wdata_q : 16'd0;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = i_ce & wb;
  assign o_we        = i_ce & wb & ~is_store_q & (dst_q != 4'd0);
  assign o_w_addr    = o_we ? dst_q : 4'd0;
  assign o_w_data    = o_we ? rdata_q : 16'd0;
  assign o_err       = i_ce & err_q;

endmodule

// File: tb/tb_lsu_seg.sv
// Directed bench for lsu_seg: loads, stores, R0 writes, timeout, clock
// enable stalls and asynchronous reset during a transaction.
module tb_lsu_seg;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ce;
  logic        i_start;
  logic        i_is_store;
  logic [15:0] i_base;
  logic [15:0] i_store_data;
  logic [3:0]  i_offset;
  logic [3:0]  i_dst;
  logic [15:0] i_seg_d;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [19:0] o_bus_addr;
  logic [15:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [15:0] i_bus_rdata;
  logic        o_we;
  logic [3:0]  o_w_addr;
  logic [15:0] o_w_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int tests = 0;
  int fails = 0;

  lsu_seg #(.ADDR_W(20), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_start(i_start),
    .i_is_store(i_is_store), .i_base(i_base), .i_store_data(i_store_data),
    .i_offset(i_offset), .i_dst(i_dst), .i_seg_d(i_seg_d),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .o_we(o_we), .o_w_addr(o_w_addr), .o_w_data(o_w_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},  32'(o_bus_req), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy),    32'd0);
    chk({tag, "_we"},   32'(o_we),      32'd0);
    chk({tag, "_done"}, 32'(o_done),    32'd0);
    chk({tag, "_err"},  32'(o_err),     32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_ce = 1'b1; i_start = 1'b0; i_is_store = 1'b0;
    i_base = '0; i_store_data = '0; i_offset = '0; i_dst = '0; i_seg_d = '0;
    i_bus_ack = 1'b0; i_bus_rdata = '0;
    #1;
    chk_idle("reset");
    chk("reset_addr", 32'(o_bus_addr), 32'h0);
    tick(); tick();
    i_rst_n = 1'b1;
    tick();

    // Load, zero-wait: 0x10000 + 0x001E
    i_seg_d = 16'h1000; i_base = 16'h0020; i_offset = 4'hE; i_dst = 4'd5;
    i_is_store = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("ld_req",  32'(o_bus_req),  32'd1);
    chk("ld_addr", 32'(o_bus_addr), 32'h1001E);
    chk("ld_bwe",  32'(o_bus_we),   32'd0);
    chk("ld_busy", 32'(o_busy),     32'd1);
    i_bus_ack = 1'b1; i_bus_rdata = 16'hBEEF;
    tick();
    chk("ld_wb_req",  32'(o_bus_req), 32'd0);
    chk("ld_we",      32'(o_we),      32'd1);
    chk("ld_waddr",   32'(o_w_addr),  32'd5);
    chk("ld_wdata",   32'(o_w_data),  32'hBEEF);
    chk("ld_done",    32'(o_done),    32'd1);
    chk("ld_wb_busy", 32'(o_busy),    32'd1);
    i_bus_ack = 1'b0;
    tick();
    chk_idle("ld_end");

    // Store, ack on 4th req cycle (coincides with counter reaching TIMEOUT)
    i_seg_d = 16'hFFFF; i_base = 16'hFFFF; i_offset = 4'h7; i_store_data = 16'h1234;
    i_is_store = 1'b1; i_dst = 4'd9; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_seg_d = 16'h0101; i_base = 16'h5A5A; i_store_data = 16'hDEAD;
    i_is_store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_req",   32'(o_bus_req),   32'd1);
      chk("st_bwe",   32'(o_bus_we),    32'd1);
      chk("st_addr",  32'(o_bus_addr),  32'hFFFF6);
      chk("st_wdata", 32'(o_bus_wdata), 32'h1234);
      chk("st_we",    32'(o_we),        32'd0);
      if (i == 3) i_bus_ack = 1'b1;
      tick();
    end
    chk("st_done", 32'(o_done), 32'd1);
    chk("st_we_wb", 32'(o_we),  32'd0);
    chk("st_err",  32'(o_err),  32'd0);
    i_bus_ack = 1'b0;
    tick();
    chk_idle("st_end");

    // Load to R0
    i_seg_d = 16'h0000; i_base = 16'h0100; i_offset = 4'h0; i_dst = 4'd0;
    i_is_store = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("r0_req",  32'(o_bus_req),  32'd1);
    chk("r0_addr", 32'(o_bus_addr), 32'h00100);
    i_bus_ack = 1'b1; i_bus_rdata = 16'h5555;
    tick();
    chk("r0_we",   32'(o_we),   32'd0);
    chk("r0_done", 32'(o_done), 32'd1);
    i_bus_ack = 1'b0;
    tick();
    chk_idle("r0_end");

    // Timeout with no ack, then a fresh start is accepted
    i_dst = 4'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(o_bus_req), 32'd1);
      chk("to_err", 32'(o_err),     32'd0);
      tick();
    end
    chk("to_req_low", 32'(o_bus_req), 32'd0);
    chk("to_err_hi",  32'(o_err),     32'd1);
    chk("to_busy",    32'(o_busy),    32'd0);
    chk("to_we",      32'(o_we),      32'd0);
    chk("to_done",    32'(o_done),    32'd0);
    tick();
    chk("to_err_once", 32'(o_err), 32'd0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("to_restart", 32'(o_bus_req), 32'd1);
    i_bus_ack = 1'b1; i_bus_rdata = 16'hA5A5;
    tick();
    chk("to_re_we",    32'(o_we),     32'd1);
    chk("to_re_waddr", 32'(o_w_addr), 32'd3);
    chk("to_re_wdata", 32'(o_w_data), 32'hA5A5);
    i_bus_ack = 1'b0;
    tick();

    // Clock-enable stall in REQ with ack high, then in WB
    i_dst = 4'd7; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("ce_req", 32'(o_bus_req), 32'd1);
    i_bus_ack = 1'b1; i_bus_rdata = 16'h1357; i_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ce_hold_req", 32'(o_bus_req), 32'd1);
      chk("ce_hold_we",  32'(o_we),      32'd0);
      chk("ce_hold_done",32'(o_done),    32'd0);
    end
    i_ce = 1'b1;
    tick();
    chk("ce_we",    32'(o_we),     32'd1);
    chk("ce_wdata", 32'(o_w_data), 32'h1357);
    i_bus_ack = 1'b0; i_ce = 1'b0;
    #1;
    chk("ce_wb_gate_we",   32'(o_we),   32'd0);
    chk("ce_wb_gate_done", 32'(o_done), 32'd0);
    tick();
    chk("ce_wb_hold_busy", 32'(o_busy), 32'd1);
    chk("ce_wb_hold_we",   32'(o_we),   32'd0);
    i_ce = 1'b1;
    #1;
    chk("ce_wb_re_we",   32'(o_we),   32'd1);
    chk("ce_wb_re_done", 32'(o_done), 32'd1);
    tick();
    chk_idle("ce_end");

    // Asynchronous reset during REQ
    i_is_store = 1'b1; i_store_data = 16'h4242; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("rst_req_before", 32'(o_bus_req), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_req_async",  32'(o_bus_req), 32'd0);
    chk("rst_busy_async", 32'(o_busy),    32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk_idle("rst_after");
    chk("rst_after_addr",  32'(o_bus_addr),  32'h0);
    chk("rst_after_wdata", 32'(o_bus_wdata), 32'h0);
    chk("rst_after_bwe",   32'(o_bus_we),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
